// File: rtl/multifield_videogen_pkg.sv
// Shared video package: raster mode record, text layout tables, field palette
// and default field/lag-row counts.
package multifield_videogen_pkg;

  localparam int DEFAULT_NUM_FIELDS = 3;
  localparam int DEFAULT_LAG_ROWS   = 4;
  localparam int MAX_FIELDS         = 8;
  localparam int MAX_LAG_ROWS       = 8;
  localparam int RES_LINE_SIZE      = 192;

  localparam logic [23:0] WHITE = 24'hFFFFFF;

  typedef struct packed {
    logic [11:0] h_sync;
    logic [11:0] h_back_porch;
    logic [11:0] v_sync;
    logic [11:0] v_back_porch;
    logic [11:0] h_text_start;
    logic [11:0] v_lag_start;
    logic [2:0]  h_res_divider;
    logic [2:0]  v_res_divider;
    logic [2:0]  h_lag_divider;
    logic [2:0]  v_lag_divider;
  } VideoMode;

  typedef enum logic {
    PH_DARK = 1'b0,
    PH_LIT  = 1'b1
  } phase_e;

  // Row 3 deliberately runs past a 512-bit lag line so the tail renders black.
  localparam logic [11:0] LAG_LEN [MAX_LAG_ROWS] = '{
    12'd64, 12'd64, 12'd64, 12'd400, 12'd64, 12'd64, 12'd64, 12'd64
  };
  localparam logic [11:0] LAG_OFS [MAX_LAG_ROWS] = '{
    12'd0, 12'd64, 12'd128, 12'd192, 12'd256, 12'd320, 12'd384, 12'd448
  };
  localparam logic [23:0] FIELD_PALETTE [MAX_FIELDS] = '{
    24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
    24'h00FFFF, 24'hFF00FF, 24'hFF8000, 24'h808080
  };

endpackage

// File: rtl/multifield_videogen_flash_sequencer.sv
// Flash sequencer: counts frame starts, toggles the flash phase every P frames
// and rotates the lit field when sequencing.
//   state   | meaning
//   PH_DARK | fields off, counting frames toward the lit phase
//   PH_LIT  | fields lit (all of them, or only field_index_o when sequencing)
module flash_sequencer
  import multifield_videogen_pkg::*;
#(
  parameter int NUM_FIELDS = DEFAULT_NUM_FIELDS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] frame_period_i,
  input  logic       seq_mode_i,
  output phase_e     phase_o,
  output logic       seq_mode_o,
  output logic [2:0] field_index_o,
  output logic       starttrigger_o
);

  phase_e     phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] last_cnt;
  logic       seq_q, seq_d;
  logic [2:0] fidx_q, fidx_d;
  logic       trig_q, trig_d;
  logic       wrap;

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= PH_DARK;
      cnt_q   <= '0;
      seq_q   <= 1'b0;
      fidx_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      fidx_q  <= fidx_d;
      trig_q  <= trig_d;
    end
  end

  // ">=" rather than "==" so a shrinking period wraps at the next start.
  assign last_cnt = (frame_period_i == 8'd0) ? 8'd0 : frame_period_i - 8'd1;
  assign wrap     = start_i && (cnt_q >= last_cnt);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    fidx_d  = fidx_q;
    trig_d  = wrap && (phase_q == PH_DARK);
    if (wrap) begin
      cnt_d = '0;
      seq_d = seq_mode_i;
      case (phase_q)
        PH_DARK: phase_d = PH_LIT;
        default: begin
          phase_d = PH_DARK;
          if (seq_q) fidx_d = (fidx_q == 3'(NUM_FIELDS - 1)) ? 3'd0 : fidx_q + 3'd1;
        end
      endcase
    end else if (start_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    phase_o        = phase_q;
    seq_mode_o     = seq_q;
    field_index_o  = fidx_q;
    starttrigger_o = trig_q;
  end

endmodule

// File: rtl/multifield_videogen.sv
// Multi-field flash video generator: flash rectangles over resolution/lag text rows.
// Define FIELD_COLOUR_EN to colour each field from FIELD_PALETTE instead of white.
module multifield_videogen
  import multifield_videogen_pkg::*;
#(
  parameter int NUM_FIELDS   = DEFAULT_NUM_FIELDS,
  parameter int LAG_ROWS     = DEFAULT_LAG_ROWS,
  parameter int LAGLINE_SIZE = 512
) (
  input  logic                     clock,
  input  logic                     reset,
  input  VideoMode                 videoMode,
  input  logic [11:0]              counterX,
  input  logic [11:0]              counterY,
  input  logic [11:0]              visible_counterX,
  input  logic [11:0]              visible_counterY,
  input  logic                     de_in,
  input  logic [NUM_FIELDS*48-1:0] field_rects,
  input  logic [7:0]               frame_period,
  input  logic                     seq_mode,
  input  logic [RES_LINE_SIZE-1:0] resolution_line,
  input  logic [LAGLINE_SIZE-1:0]  lagdisplay_line,
  output logic                     starttrigger,
  output logic [2:0]               field_index,
  output logic                     de_out,
  output logic [23:0]              data
);

  logic                  frame_start;
  phase_e                phase;
  logic                  seq_active;
  logic [NUM_FIELDS-1:0] fld_in;
  logic [11:0]           text_xo, lag_col, lag_h, lag_base;
  logic                  res_bit, lag_bit;

  logic        de1_q;
  logic        fld_hit_q, fld_hit_d;
  logic        res_hit_q, res_hit_d, res_ok_q, res_ok_d;
  logic [11:0] res_idx_q, res_idx_d;
  logic        lag_hit_q, lag_hit_d, lag_ok_q, lag_ok_d;
  logic [11:0] lag_idx_q, lag_idx_d;
  logic        de2_q;
  logic [23:0] data_q, data_d;
`ifdef FIELD_COLOUR_EN
  logic [2:0]  fld_id_q, fld_id_d;
`endif

  assign frame_start = (counterX == videoMode.h_sync + videoMode.h_back_porch) &&
                       (counterY == videoMode.v_sync + videoMode.v_back_porch);

  flash_sequencer #(.NUM_FIELDS(NUM_FIELDS)) u_seq (
    .clock          (clock),
    .reset          (reset),
    .start_i        (frame_start),
    .frame_period_i (frame_period),
    .seq_mode_i     (seq_mode),
    .phase_o        (phase),
    .seq_mode_o     (seq_active),
    .field_index_o  (field_index),
    .starttrigger_o (starttrigger)
  );

  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
    logic [11:0] x0, x1, y0, y1;
    assign {x0, x1, y0, y1} = field_rects[i*48 +: 48];
    assign fld_in[i] = (phase == PH_LIT) && (!seq_active || field_index == 3'(i)) &&
                       (visible_counterX >= x0) && (visible_counterX < x1) &&
                       (visible_counterY >= y0) && (visible_counterY < y1);
  end

  always_comb begin
    fld_hit_d = |fld_in;
`ifdef FIELD_COLOUR_EN
    fld_id_d = '0;
    for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
      if (fld_in[i]) fld_id_d = 3'(i);
    end
`endif
  end

  // Underflow left of the text origin wraps to a huge index and is rejected below.
  assign text_xo   = visible_counterX - videoMode.h_text_start;
  assign res_idx_d = text_xo >> videoMode.h_res_divider;
  assign res_hit_d = visible_counterY < (12'd16 << videoMode.v_res_divider);
  assign res_ok_d  = (visible_counterX >= videoMode.h_text_start) &&
                     (res_idx_d < 12'(RES_LINE_SIZE));
  assign lag_col   = text_xo >> videoMode.h_lag_divider;
  assign lag_h     = 12'd16 << videoMode.v_lag_divider;

  always_comb begin
    lag_hit_d = 1'b0;
    lag_idx_d = '0;
    lag_base  = '0;
    for (int r = LAG_ROWS - 1; r >= 0; r--) begin
      lag_base = videoMode.v_lag_start + (12'(16 * r) << videoMode.v_lag_divider);
      if ((visible_counterY >= lag_base) && ((visible_counterY - lag_base) < lag_h) &&
          (visible_counterX >= videoMode.h_text_start) && (lag_col < LAG_LEN[r])) begin
        lag_hit_d = 1'b1;
        lag_idx_d = LAG_OFS[r] + lag_col;
      end
    end
  end

  assign lag_ok_d = {20'd0, lag_idx_d} < 32'(LAGLINE_SIZE);

  always_ff @(posedge clock) begin
    if (reset) begin
      de1_q     <= 1'b0;
      fld_hit_q <= 1'b0;
      res_hit_q <= 1'b0;
      res_ok_q  <= 1'b0;
      res_idx_q <= '0;
      lag_hit_q <= 1'b0;
      lag_ok_q  <= 1'b0;
      lag_idx_q <= '0;
`ifdef FIELD_COLOUR_EN
      fld_id_q  <= '0;
`endif
      de2_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      de1_q     <= de_in;
      fld_hit_q <= fld_hit_d;
      res_hit_q <= res_hit_d;
      res_ok_q  <= res_ok_d;
      res_idx_q <= res_idx_d;
      lag_hit_q <= lag_hit_d;
      lag_ok_q  <= lag_ok_d;
      lag_idx_q <= lag_idx_d;
`ifdef FIELD_COLOUR_EN
      fld_id_q  <= fld_id_d;
`endif
      de2_q     <= de1_q;
      data_q    <= data_d;
    end
  end

  // Mask-and-reduce keeps every bitmap select in range whatever the index.
  assign res_bit = |(resolution_line & (RES_LINE_SIZE'(1) << res_idx_q));
  assign lag_bit = |(lagdisplay_line & (LAGLINE_SIZE'(1) << lag_idx_q));

  always_comb begin
    data_d = '0;
    if (de1_q) begin
      if (fld_hit_q) begin
`ifdef FIELD_COLOUR_EN
        data_d = FIELD_PALETTE[fld_id_q];
`else
        data_d = WHITE;
`endif
      end else if (res_hit_q) begin
        data_d = (res_ok_q && res_bit) ? WHITE : 24'h0;
      end else if (lag_hit_q) begin
        data_d = (lag_ok_q && lag_bit) ? WHITE : 24'h0;
      end
    end
  end

  assign de_out = de2_q;
  assign data   = data_q;

endmodule

// File: tb/tb_multifield_videogen.sv
// Directed bench for multifield_videogen: flash sequencing, text rows, pipeline latency, reset.
module tb_multifield_videogen;
  import multifield_videogen_pkg::*;

`ifdef FIELD_COLOUR_EN
  localparam bit PAL = 1'b1;
`else
  localparam bit PAL = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  VideoMode      vm;
  logic [11:0]   cx, cy, vx, vy;
  logic          de_in;
  logic [143:0]  rects;
  logic [7:0]    fp;
  logic          seq;
  logic [191:0]  res_line;
  logic [511:0]  lag_line;
  logic          trig;
  logic [2:0]    fidx;
  logic          de_out;
  logic [23:0]   data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  multifield_videogen dut (
    .clock            (clock),
    .reset            (reset),
    .videoMode        (vm),
    .counterX         (cx),
    .counterY         (cy),
    .visible_counterX (vx),
    .visible_counterY (vy),
    .de_in            (de_in),
    .field_rects      (rects),
    .frame_period     (fp),
    .seq_mode         (seq),
    .resolution_line  (res_line),
    .lagdisplay_line  (lag_line),
    .starttrigger     (trig),
    .field_index      (fidx),
    .de_out           (de_out),
    .data             (data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] fcol(input logic [2:0] i);
    return PAL ? FIELD_PALETTE[i] : 24'hFFFFFF;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic frame_start();
    cx = 12'd30;
    cy = 12'd5;
    tick();
    cx = 12'd0;
    cy = 12'd0;
  endtask

  // Pixel enters, is followed by a blank pixel, and must appear exactly two edges later.
  task automatic pixel(input string tag, input int x, input int y, input logic de,
                       input logic [23:0] exp);
    vx = 12'(x);
    vy = 12'(y);
    de_in = de;
    tick();
    de_in = 1'b0;
    vx = 12'd0;
    vy = 12'd0;
    tick();
    check({tag, "_data"}, 32'(data), 32'(exp));
    check({tag, "_de"}, 32'(de_out), 32'(de));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] trig_a;
    logic [6:0] trig_b;
    int         fidx_b [7];

    vm = '0;
    vm.h_sync       = 12'd10;
    vm.h_back_porch = 12'd20;
    vm.v_sync       = 12'd2;
    vm.v_back_porch = 12'd3;
    vm.h_text_start = 12'd0;
    vm.v_lag_start  = 12'd100;
    // {x0,x1,y0,y1} per field, field 0 in the low bits
    rects = {12'd80, 12'd96, 12'd100, 12'd116,
             12'd40, 12'd56, 12'd100, 12'd116,
             12'd0,  12'd16, 12'd100, 12'd116};
    res_line = '0;
    res_line[0] = 1'b1;
    res_line[2] = 1'b1;
    res_line[191] = 1'b1;
    lag_line = '0;
    lag_line[511:192] = '1;
    lag_line[5] = 1'b1;
    lag_line[67] = 1'b1;
    fp = 8'd2;
    seq = 1'b0;
    cx = '0; cy = '0;
    vx = '0; vy = '0;
    de_in = 1'b1;

    // Reset held with a white resolution pixel at the input
    tick();
    tick();
    check("rst_data", 32'(data), 32'h0);
    check("rst_de", 32'(de_out), 32'h0);
    check("rst_trig", 32'(trig), 32'h0);
    check("rst_fidx", 32'(fidx), 32'h0);
    de_in = 1'b0;
    reset = 1'b0;

    // Period 2, all fields: trigger after starts 2 and 6
    trig_a = 8'b0010_0010;
    for (int k = 0; k < 8; k++) begin
      frame_start();
      check("a_trig", 32'(trig), 32'(trig_a[k]));
      if (k == 1) begin
        tick();
        check("a_trig_drop", 32'(trig), 32'h0);
        pixel("a_f0_x0", 0, 100, 1'b1, fcol(3'd0));
        pixel("a_f2_last", 95, 115, 1'b1, fcol(3'd2));
        pixel("a_f0_x1", 16, 100, 1'b1, 24'h0);
        pixel("a_f0_noden", 0, 100, 1'b0, 24'h0);
      end
      if (k == 3) begin
        pixel("a_dark_f0", 0, 100, 1'b1, 24'h0);
        pixel("res_bit2", 2, 15, 1'b1, 24'hFFFFFF);
        pixel("res_below", 2, 16, 1'b1, 24'h0);
        pixel("res_bit191", 191, 0, 1'b1, 24'hFFFFFF);
        pixel("res_bit192", 192, 0, 1'b1, 24'h0);
        pixel("res_bit1", 1, 0, 1'b1, 24'h0);
        pixel("lag_r0_b5", 5, 100, 1'b1, 24'hFFFFFF);
        pixel("lag_r0_b4", 4, 100, 1'b1, 24'h0);
        pixel("lag_r1_start", 3, 116, 1'b1, 24'hFFFFFF);
        pixel("lag_r0_end", 3, 115, 1'b1, 24'h0);
        pixel("lag_r3_511", 319, 148, 1'b1, 24'hFFFFFF);
        pixel("lag_r3_512", 320, 148, 1'b1, 24'h0);
        pixel("lag_r3_last", 319, 163, 1'b1, 24'hFFFFFF);
        pixel("lag_past_rows", 319, 164, 1'b1, 24'h0);
      end
    end

    // Text origin moved right: pixels left of it underflow and must be black
    vm.h_text_start = 12'd8;
    res_line = '1;
    pixel("res_underflow", 4, 0, 1'b1, 24'h0);
    pixel("res_origin", 8, 0, 1'b1, 24'hFFFFFF);
    vm.h_text_start = 12'd0;
    res_line = '0;
    res_line[0] = 1'b1;
    res_line[2] = 1'b1;
    res_line[191] = 1'b1;

    // Period 0 acts as 1; sequencing rotates the lit field; mode change waits for a toggle
    fp = 8'd0;
    seq = 1'b1;
    do_reset();
    trig_b = 7'b101_0101;
    fidx_b = '{0, 1, 1, 2, 2, 0, 0};
    for (int k = 0; k < 7; k++) begin
      frame_start();
      check("b_trig", 32'(trig), 32'(trig_b[k]));
      check("b_fidx", 32'(fidx), 32'(fidx_b[k]));
      case (k)
        0: begin
          pixel("b0_f0", 0, 100, 1'b1, fcol(3'd0));
          pixel("b0_f1", 40, 100, 1'b1, 24'h0);
        end
        1: pixel("b1_f0", 0, 100, 1'b1, 24'h0);
        2: begin
          pixel("b2_f1", 40, 100, 1'b1, fcol(3'd1));
          pixel("b2_f0", 0, 100, 1'b1, 24'h0);
        end
        4: begin
          pixel("b4_f2", 80, 100, 1'b1, fcol(3'd2));
          pixel("b4_f1", 40, 100, 1'b1, 24'h0);
          seq = 1'b0;
          pixel("b4_seq_held", 0, 100, 1'b1, 24'h0);
        end
        6: begin
          pixel("b6_all_f0", 0, 100, 1'b1, fcol(3'd0));
          pixel("b6_all_f1", 40, 100, 1'b1, fcol(3'd1));
        end
        default: ;
      endcase
    end

    // Period shrinks 10 -> 2 with the count at 5: wraps on the next start
    fp = 8'd10;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      frame_start();
      check("c_trig_p10", 32'(trig), 32'h0);
    end
    fp = 8'd2;
    frame_start();
    check("c_trig_shrink", 32'(trig), 32'h1);
    pixel("c_f1_lit", 40, 100, 1'b1, fcol(3'd1));

    // Reset mid-line while lit: outputs clear, in-flight pixel is dropped
    vx = 12'd40;
    vy = 12'd100;
    de_in = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("d_rst_data", 32'(data), 32'h0);
    check("d_rst_de", 32'(de_out), 32'h0);
    check("d_rst_trig", 32'(trig), 32'h0);
    check("d_rst_fidx", 32'(fidx), 32'h0);
    reset = 1'b0;
    de_in = 1'b0;
    vx = 12'd0;
    vy = 12'd0;
    tick();
    check("d_flushed", 32'(data), 32'h0);
    pixel("d_dark", 40, 100, 1'b1, 24'h0);
    frame_start();
    check("d_trig_1st", 32'(trig), 32'h0);
    frame_start();
    check("d_trig_2nd", 32'(trig), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multifield_videogen.md
MULTIFIELD_VIDEOGEN -- requirements
Module: multifield_videogen

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 3: number of flash rectangles, 1..8.
REQ-002 SHALL have parameter LAG_ROWS, default 4: number of lag-text rows, 1..8.
REQ-003 SHALL have parameter LAGLINE_SIZE, default 512: lag-text bitmap width in bits.
REQ-004 SHALL have port clock, input, 1 bit: single clock domain.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port videoMode, input, VideoMode: timing, dividers and text origins.
REQ-007 SHALL have ports counterX and counterY, input, 12 bits each: raw raster position.
REQ-008 SHALL have ports visible_counterX and visible_counterY, input, 12 bits each: active-area position.
REQ-009 SHALL have port de_in, input, 1 bit: active video flag aligned to visible counters.
REQ-010 SHALL have port field_rects, input, NUM_FIELDS*48 bits: per field {x0,x1,y0,y1}, 12 bits each, half-open.
REQ-011 SHALL have port frame_period, input, 8 bits: frames per flash phase.
REQ-012 SHALL have port seq_mode, input, 1 bit: 0 = all fields together, 1 = one field per phase, rotating.
REQ-013 SHALL have port resolution_line, input, 192 bits: resolution text row bitmap.
REQ-014 SHALL have port lagdisplay_line, input, LAGLINE_SIZE bits: lag text bitmap.
REQ-015 SHALL have port starttrigger, output, 1 bit: one-cycle pulse when fields light.
REQ-016 SHALL have port field_index, output, 3 bits: currently lit field in seq_mode.
REQ-017 SHALL have port de_out, output, 1 bit: de_in delayed to match data.
REQ-018 SHALL have port data, output, 24 bits: RGB888 pixel.

Function
REQ-019 SHALL detect frame start when counterX == h_sync+h_back_porch and counterY == v_sync+v_back_porch, one cycle per frame.
REQ-020 SHALL count frames 0..P-1, where P = max(frame_period,1); on a start with count == P-1, or count >= P-1 after frame_period shrinks, count SHALL wrap to 0 and phase SHALL toggle.
REQ-021 SHALL assert starttrigger for exactly one cycle, the cycle after the start that toggles phase 0->1; otherwise starttrigger SHALL be 0.
REQ-022 In seq_mode=1, field_index SHALL advance on each 1->0 phase toggle and wrap from NUM_FIELDS-1 to 0; only that field SHALL be lit.
REQ-023 A seq_mode change SHALL take effect only at the next phase toggle; the sampled value SHALL be held in a register.
REQ-024 The pixel path SHALL be a 2-stage pipeline: stage 1 registers region hits and bit indices; stage 2 registers data. Latency from visible counters/de_in to data/de_out SHALL be exactly 2 cycles.
REQ-025 Pixel priority SHALL be, highest first: lit field -> field colour; resolution row, ypos < 16<<v_res_divider -> white/black by bitmap; lag rows -> white/black; else 0.
REQ-026 Lag row r SHALL span ypos in [v_lag_start + (16r<<v_lag_divider), +16<<v_lag_divider), length LAG_LEN[r], bit offset LAG_OFS[r]. A bit index >= LAGLINE_SIZE SHALL yield black.
REQ-027 Bit-index arithmetic SHALL be 12 bits unsigned; an underflowed index SHALL yield black and never an out-of-range select.
REQ-028 data SHALL be 0 whenever the stage-2 de is 0.

Reset
REQ-029 While reset is high, the frame count, phase, field_index, starttrigger, de_out, data and the pipeline registers SHALL be 0 at the next clock edge; the seq_mode register SHALL be 0.
REQ-030 Reset mid-frame SHALL discard in-flight pixels; the first starttrigger after reset SHALL follow the P-th detected frame start.

Configuration
REQ-031 With FIELD_COLOUR_EN defined, field i SHALL output FIELD_PALETTE[i]; without it, all fields SHALL output 24'hFFFFFF and the palette logic SHALL be absent.

Structure
REQ-032 The VideoMode typedef, LAG_LEN/LAG_OFS arrays, FIELD_PALETTE and the default NUM_FIELDS/LAG_ROWS values SHALL reside in the shared video package.
REQ-033 Frame counting, phase and field rotation SHALL be the sub-module flash_sequencer; the pixel pipeline SHALL stay in the top level.

Verification
REQ-034 frame_period=2, seq_mode=0: phase toggles every 2 frame starts; starttrigger pulses once every 4 frames; all fields are white when lit.
REQ-035 seq_mode=1, NUM_FIELDS=3: field_index goes 0,1,2,0 on successive off-phases; only the indexed rectangle is non-zero.
REQ-036 frame_period=0: behaves as 1; phase toggles on every frame start.
REQ-037 frame_period changes 10->2 while count=5: wraps at the next frame start and toggles phase.
REQ-038 Pixel at field x0 = first lag-row pixel with de_in=1: data=FFFFFF exactly 2 cycles later; x1-1 lit, x1 not lit; de_in=0 gives data=0.
REQ-039 Reset asserted mid-line with phase=1: next cycle all outputs are 0; with FIELD_COLOUR_EN defined, field 1 outputs FIELD_PALETTE[1].
